// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Purpose  : Shared types, latencies and helpers for the pipelined CAM.
//            cam_addr_w()  - index width for a given entry count
//            cam_result_t  - one registered search result {hit, multi, index}
// Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

  localparam int CAM_SEARCH_LAT = 2;
  localparam int CAM_READ_LAT   = 1;

  // Result index is stored at a fixed maximum width so the struct can live
  // in the package; the top truncates it to its own index width.
  localparam int CAM_IDX_MAX_W  = 32;

  function automatic int cam_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic                     hit;
    logic                     multi;
    logic [CAM_IDX_MAX_W-1:0] index;
  } cam_result_t;

endpackage
`default_nettype wire

// File: rtl/cam_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : cam_priority_encoder
// Purpose  : Combinational reduction of a CAM match vector.
// Ports    : i_match  [DEPTH]      per-entry match flags
//            o_hit                 at least one flag set
//            o_multi               two or more flags set
//            o_index  [ADDR_WIDTH] lowest set position, 0 when none
// Revision : 1.0 - initial release
// ============================================================================
module cam_priority_encoder
  import cam_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = cam_addr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]      i_match,
  output logic                  o_hit,
  output logic                  o_multi,
  output logic [ADDR_WIDTH-1:0] o_index
);

  always_comb begin
    o_hit   = 1'b0;
    o_multi = 1'b0;
    o_index = '0;
    // Descending scan so the lowest matching position is written last.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_match[k]) begin
        o_index = ADDR_WIDTH'(k);
      end
    end
    // A second match is any set bit seen after o_hit already went high.
    for (int k = 0; k < DEPTH; k++) begin
      if (i_match[k]) begin
        o_multi = o_multi | o_hit;
        o_hit   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : cam_pipelined
// Purpose  : DEPTH x WIDTH content-addressable tag store with per-entry valid
//            bits, indexed read (1 cycle) / write, single-entry invalidate,
//            global flush and a 2-stage pipelined associative search that
//            reports hit, multi-hit and lowest matching index.
// Config   : CAM_MASK_EN - when defined, adds search_mask_i (1 = compare bit);
//            otherwise search is an exact full-width compare.
// Ports    : clk_i, rst_i (async, active high)
//            read_enable_i/read_index_i     -> read_valid_o/read_value_o
//            write_enable_i/write_index_i/write_data_i
//            inval_enable_i/inval_index_i, flush_i
//            search_enable_i/search_data_i[/search_mask_i]
//                                           -> search_valid_o/hit/multi/index
// Revision : 1.0 - initial release
// ============================================================================
module cam_pipelined
  import cam_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = cam_addr_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  inval_enable_i,
  input  logic [ADDR_WIDTH-1:0] inval_index_i,
  input  logic                  flush_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
`ifdef CAM_MASK_EN
  input  logic [WIDTH-1:0]      search_mask_i,
`endif
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic                  search_multi_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      w_valid_next;
  logic [DEPTH-1:0]      w_match;
  logic [DEPTH-1:0]      r_match;

  logic                  w_rd_valid;
  logic [WIDTH-1:0]      w_rd_data;
  logic                  w_rd_take;
  logic                  r_read_valid;
  logic [WIDTH-1:0]      r_read_value;

  logic                  r_s1_valid;
  logic                  r_s2_valid;
  logic                  w_enc_hit;
  logic                  w_enc_multi;
  logic [ADDR_WIDTH-1:0] w_enc_index;
  cam_result_t           r_result;
  logic                  w_unused_index;

  // --------------------------------------------------------------------------
  // Storage. Data is not reset; indices with no matching entry (>= DEPTH)
  // select nothing and are therefore ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin : p_mem
    for (int k = 0; k < DEPTH; k++) begin
      if (write_enable_i && (write_index_i == ADDR_WIDTH'(k))) begin
        r_mem[k] <= write_data_i;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    // Invalidate beats write on the same entry; flush beats both (below).
    assign w_valid_next[k] =
        ~(inval_enable_i && (inval_index_i == ADDR_WIDTH'(k))) &
        (r_valid[k] | (write_enable_i && (write_index_i == ADDR_WIDTH'(k))));

    // Compare against pre-edge state: a write in the same cycle is not seen.
`ifdef CAM_MASK_EN
    assign w_match[k] = r_valid[k] & ~|((r_mem[k] ^ search_data_i) & search_mask_i);
`else
    assign w_match[k] = r_valid[k] & (r_mem[k] == search_data_i);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : p_valid
    if (rst_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
    end
  end

  // --------------------------------------------------------------------------
  // Indexed read, one cycle latency.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_valid = 1'b0;
    w_rd_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (read_index_i == ADDR_WIDTH'(k)) begin
        w_rd_valid = r_valid[k];
        w_rd_data  = r_mem[k];
      end
    end
  end

  assign w_rd_take = read_enable_i & w_rd_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin : p_read
    if (rst_i) begin
      r_read_valid <= 1'b0;
      r_read_value <= '0;
    end else begin
      r_read_valid <= w_rd_take;
      r_read_value <= w_rd_take ? w_rd_data : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Search pipeline: stage 1 captures the match vector, stage 2 captures the
  // encoded result. Flush/invalidate after stage 1 do not alter a capture.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin : p_stage1
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_match    <= '0;
    end else begin
      r_s1_valid <= search_enable_i;
      r_match    <= search_enable_i ? w_match : '0;
    end
  end

  cam_priority_encoder #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prio (
    .i_match (r_match),
    .o_hit   (w_enc_hit),
    .o_multi (w_enc_multi),
    .o_index (w_enc_index)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin : p_stage2
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= '{hit: w_enc_hit, multi: w_enc_multi,
                      index: CAM_IDX_MAX_W'(w_enc_index)};
      end else begin
        r_result <= '0;
      end
    end
  end

  assign w_unused_index = ^r_result.index[CAM_IDX_MAX_W-1:ADDR_WIDTH];

  assign read_valid_o   = r_read_valid;
  assign read_value_o   = r_read_value;
  assign search_valid_o = r_s2_valid;
  assign search_hit_o   = r_result.hit;
  assign search_multi_o = r_result.multi;
  assign search_index_o = r_result.index[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_cam_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_pipelined
// Purpose  : Self-checking bench for cam_pipelined (32x32 main instance plus
//            a 12x8 instance for non-power-of-two index handling).
//            Build with +define+CAM_MASK_EN to exercise masked search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rd_en, wr_en, inv_en, flush, s_en;
  logic [4:0]  rd_idx, wr_idx, inv_idx;
  logic [31:0] wr_data, s_key;
`ifdef CAM_MASK_EN
  logic [31:0] s_mask;
`endif
  logic        rv, sv, hit, multi;
  logic [31:0] rval;
  logic [4:0]  sidx;

  logic        d_rd_en, d_wr_en, d_s_en;
  logic [3:0]  d_rd_idx, d_wr_idx;
  logic [7:0]  d_wr_data, d_s_key;
  logic        d_rv, d_sv, d_hit, d_multi;
  logic [7:0]  d_rval;
  logic [3:0]  d_sidx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_pipelined #(.WIDTH(32), .DEPTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .read_enable_i(rd_en), .read_index_i(rd_idx),
    .write_enable_i(wr_en), .write_index_i(wr_idx), .write_data_i(wr_data),
    .inval_enable_i(inv_en), .inval_index_i(inv_idx), .flush_i(flush),
    .search_enable_i(s_en), .search_data_i(s_key),
`ifdef CAM_MASK_EN
    .search_mask_i(s_mask),
`endif
    .read_valid_o(rv), .read_value_o(rval),
    .search_valid_o(sv), .search_hit_o(hit), .search_multi_o(multi),
    .search_index_o(sidx)
  );

  cam_pipelined #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clk_i(clk), .rst_i(rst),
    .read_enable_i(d_rd_en), .read_index_i(d_rd_idx),
    .write_enable_i(d_wr_en), .write_index_i(d_wr_idx), .write_data_i(d_wr_data),
    .inval_enable_i(1'b0), .inval_index_i(4'd0), .flush_i(1'b0),
    .search_enable_i(d_s_en), .search_data_i(d_s_key),
`ifdef CAM_MASK_EN
    .search_mask_i(8'hFF),
`endif
    .read_valid_o(d_rv), .read_value_o(d_rval),
    .search_valid_o(d_sv), .search_hit_o(d_hit), .search_multi_o(d_multi),
    .search_index_o(d_sidx)
  );

  typedef struct {
    logic        rd_en;  logic [4:0]  rd_idx;
    logic        wr_en;  logic [4:0]  wr_idx;  logic [31:0] wr_data;
    logic        inv_en; logic [4:0]  inv_idx; logic        flush;
    logic        s_en;   logic [31:0] s_key;
    logic        e_rv;   logic [31:0] e_rval;
    logic        e_sv;   logic        e_hit;   logic        e_multi; logic [4:0] e_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic re, input logic [4:0] ri, input logic we, input logic [4:0] wi,
      input logic [31:0] wd, input logic ie, input logic [4:0] ii, input logic fl,
      input logic se, input logic [31:0] sk, input logic erv, input logic [31:0] erval,
      input logic esv, input logic eh, input logic em, input logic [4:0] ei);
    vec_t v;
    v.rd_en = re; v.rd_idx = ri; v.wr_en = we; v.wr_idx = wi; v.wr_data = wd;
    v.inv_en = ie; v.inv_idx = ii; v.flush = fl; v.s_en = se; v.s_key = sk;
    v.e_rv = erv; v.e_rval = erval; v.e_sv = esv; v.e_hit = eh; v.e_multi = em; v.e_idx = ei;
    return v;
  endfunction

  // Reference state: what the CAM holds, as seen by the spec's rules.
  logic [31:0] m_mem [32];
  bit          m_valid [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_en = 0; rd_idx = 0; wr_en = 0; wr_idx = 0; wr_data = 0;
    inv_en = 0; inv_idx = 0; flush = 0; s_en = 0; s_key = 0;
`ifdef CAM_MASK_EN
    s_mask = '1;
`endif
    d_rd_en = 0; d_rd_idx = 0; d_wr_en = 0; d_wr_idx = 0; d_wr_data = 0;
    d_s_en = 0; d_s_key = 0;
  endtask

  task automatic search_check(input string name, input logic [31:0] key,
                              input logic e_hit, input logic e_multi, input logic [4:0] e_idx);
    s_en = 1; s_key = key;
    tick();
    s_en = 0;
    tick();
    chk(name, {sv, hit, multi, sidx}, {1'b1, e_hit, e_multi, e_idx});
  endtask

  function automatic logic [7:0] model_search(input logic [31:0] key, input logic [31:0] mask);
    int hits[$];
    for (int k = 0; k < 32; k++) begin
      if (m_valid[k] && (((m_mem[k] ^ key) & mask) == 32'd0)) hits.push_back(k);
    end
    if (hits.size() == 0) return 8'b1000_0000;
    return {1'b1, 1'b1, hits.size() > 1, 5'(hits[0])};
  endfunction

  initial begin
    logic [32:0] exp_r;
    logic [7:0]  exp_s_now, exp_s_pend;
    logic [31:0] mask_r;

    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_read",   {rv, rval},                 64'd0);
    chk("reset_search", {sv, hit, multi, sidx},     64'd0);
    chk("reset_d12",    {d_rv, d_rval, d_sv, d_hit, d_multi, d_sidx}, 64'd0);
    rst = 0;

    // ---------------- directed table ----------------
    // Expected fields are the outputs just after that row's clock edge.
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h0,        0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,0,0,0));
    vecs.push_back(mk(0,0, 1,5,32'hDEADBEEF, 0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 1,9,32'hDEADBEEF, 0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(1,9, 0,0,0,            0,0,0, 1,32'hDEADBEEF, 1,32'hDEADBEEF, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,1,1,5));
    vecs.push_back(mk(0,0, 1,3,32'h1234,     0,0,0, 1,32'h1234,     0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h1234,     0,0,            1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,1,0,3));
    vecs.push_back(mk(0,0, 1,7,32'hAAAA,     0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 1,7,32'hBBBB,     1,7,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(1,7, 0,0,0,            0,0,0, 1,32'hBBBB,     0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,0,0,0));
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk(0,0, 1,5'(i),32'h100 + i, 0,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h105,      0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,1, 0,0,            0,0,            1,1,0,5));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h100,      0,0,            0,0,0,0));
    vecs.push_back(mk(1,31,0,0,0,            0,0,0, 1,32'h11F,      0,0,            1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,32'h11,       0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 1,2,32'h22,       0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 1,4,32'h44,       0,0,0, 0,0,            0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h11,       0,0,            0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h22,       0,0,            1,1,0,1));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h33,       0,0,            1,1,0,2));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 1,32'h44,       0,0,            1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            1,1,0,4));
    vecs.push_back(mk(0,0, 0,0,0,            0,0,0, 0,0,            0,0,            0,0,0,0));

    foreach (vecs[i]) begin
      rd_en = vecs[i].rd_en; rd_idx = vecs[i].rd_idx;
      wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx; wr_data = vecs[i].wr_data;
      inv_en = vecs[i].inv_en; inv_idx = vecs[i].inv_idx; flush = vecs[i].flush;
      s_en = vecs[i].s_en; s_key = vecs[i].s_key;
      tick();
      chk($sformatf("vec%0d_read", i), {rv, rval}, {vecs[i].e_rv, vecs[i].e_rval});
      chk($sformatf("vec%0d_search", i), {sv, hit, multi, sidx},
          {vecs[i].e_sv, vecs[i].e_hit, vecs[i].e_multi, vecs[i].e_idx});
    end
    idle_inputs();

    // ---------------- reset with searches in flight ----------------
    s_en = 1; s_key = 32'h11;
    tick();
    s_key = 32'h22;
    rst = 1;
    #1;
    chk("rst_async_outputs", {rv, rval, sv, hit, multi, sidx}, 64'd0);
    tick();
    s_en = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_no_strobe%0d", i), {sv, hit, multi, sidx}, 64'd0);
    end
    search_check("rst_cleared_valid", 32'h11, 0, 0, 0);

`ifdef CAM_MASK_EN
    // ---------------- masked search ----------------
    wr_en = 1; wr_idx = 2; wr_data = 32'hAB00_0012;
    tick();
    wr_idx = 6; wr_data = 32'h0000_0001;
    tick();
    wr_en = 0;
    s_mask = 32'hFFFF_0000;
    search_check("mask_upper", 32'hAB00_FFFF, 1, 0, 2);
    s_mask = 32'h0;
    search_check("mask_zero", 32'h1234_5678, 1, 1, 2);
    s_mask = '1;
    search_check("mask_full_miss", 32'hAB00_FFFF, 0, 0, 0);
`endif

    // ---------------- 12 x 8 instance: out-of-range index ----------------
    d_wr_en = 1; d_wr_idx = 4'd12; d_wr_data = 8'h5A;
    tick();
    d_wr_idx = 4'd11;
    tick();
    d_wr_en = 0; d_rd_en = 1; d_rd_idx = 4'd12; d_s_en = 1; d_s_key = 8'h5A;
    tick();
    chk("d12_read_oob", {d_rv, d_rval}, 64'd0);
    d_rd_idx = 4'd11; d_s_en = 0;
    tick();
    chk("d12_read_11", {d_rv, d_rval}, {1'b1, 8'h5A});
    chk("d12_search", {d_sv, d_hit, d_multi, d_sidx}, {1'b1, 1'b1, 1'b0, 4'd11});
    idle_inputs();

    // ---------------- randomized run against the reference model ----------------
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 32; k++) m_valid[k] = 0;
    exp_s_pend = 8'd0;
    for (int c = 0; c < 600; c++) begin
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_idx  = 5'($urandom_range(0, 31));
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_idx  = 5'($urandom_range(0, 31));
      wr_data = 32'hC0DE_0000 | 32'($urandom_range(0, 5));
      inv_en  = ($urandom_range(0, 4) == 0);
      inv_idx = ($urandom_range(0, 1) == 1) ? wr_idx : 5'($urandom_range(0, 31));
      flush   = ($urandom_range(0, 40) == 0);
      s_en    = ($urandom_range(0, 4) != 0);
      s_key   = 32'hC0DE_0000 | 32'($urandom_range(0, 5));
      mask_r  = '1;
`ifdef CAM_MASK_EN
      case ($urandom_range(0, 3))
        0:       mask_r = 32'hFFFF_FFF8;
        1:       mask_r = 32'h0;
        2:       mask_r = $urandom;
        default: mask_r = '1;
      endcase
      s_mask = mask_r;
`endif
      exp_r     = (rd_en && m_valid[rd_idx]) ? {1'b1, m_mem[rd_idx]} : 33'd0;
      exp_s_now = s_en ? model_search(s_key, mask_r) : 8'd0;
      tick();
      if (wr_en) begin
        m_mem[wr_idx]   = wr_data;
        m_valid[wr_idx] = 1;
      end
      if (inv_en) m_valid[inv_idx] = 0;
      if (flush) for (int k = 0; k < 32; k++) m_valid[k] = 0;
      chk($sformatf("rand%0d_read", c), {rv, rval}, exp_r);
      chk($sformatf("rand%0d_search", c), {sv, hit, multi, sidx}, exp_s_pend);
      exp_s_pend = exp_s_now;
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
